// File: rtl/bus_arbiter.sv
// bus_arbiter: shares the single CPU memory port between the instruction
// fetcher and the execution unit, and runs the OAM DMA sequencer.
// A write to the DMA page register halts the CPU and copies 256 bytes
// from {page,00..FF} to the OAM data port.
//
// Ports:
//   phi1, reset              clock, synchronous active-high reset
//   fetch_req/addr/gnt       fetcher read channel
//   exec_req/we/addr/wdata   execution unit channel, exec_gnt grant
//   mem_*                    memory port (mem_rdata valid in access cycle)
//   rdata/_valid/_owner      registered read return (owner 1 = exec)
//   cpu_halt                 CPU stall while any DMA state is active
//   dma_idx                  current DMA byte index
module bus_arbiter #(
    parameter int unsigned           REG_WIDTH     = 8,
    parameter int unsigned           ADDR_WIDTH    = 16,
    parameter logic [ADDR_WIDTH-1:0] DMA_REG_ADDR  = 16'h4014,
    parameter logic [ADDR_WIDTH-1:0] OAM_DATA_ADDR = 16'h2004
) (
    input  logic                  phi1,
    input  logic                  reset,
    input  logic                  fetch_req,
    input  logic [ADDR_WIDTH-1:0] fetch_addr,
    output logic                  fetch_gnt,
    input  logic                  exec_req,
    input  logic                  exec_we,
    input  logic [ADDR_WIDTH-1:0] exec_addr,
    input  logic [REG_WIDTH-1:0]  exec_wdata,
    output logic                  exec_gnt,
    input  logic [REG_WIDTH-1:0]  mem_rdata,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [REG_WIDTH-1:0]  mem_wdata,
    output logic                  mem_we,
    output logic                  mem_en,
    output logic [REG_WIDTH-1:0]  rdata,
    output logic                  rdata_valid,
    output logic                  rdata_owner,
    output logic                  cpu_halt,
    output logic [REG_WIDTH-1:0]  dma_idx
);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] HALT  = 3'd1;
    localparam logic [2:0] ALIGN = 3'd2;
    localparam logic [2:0] READ  = 3'd3;
    localparam logic [2:0] WRITE = 3'd4;

    logic [2:0]           state;
    logic [2:0]           state_nx;
    logic                 parity;
    logic                 trigger;
    logic                 rd_take;
    logic [REG_WIDTH-1:0] dma_page;
    logic [REG_WIDTH-1:0] dma_buf;

    // State register
    always_ff @(posedge phi1) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next state, grants and memory port drive
    always_comb begin
        state_nx  = state;
        fetch_gnt = 1'b0;
        exec_gnt  = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_we    = 1'b0;
        mem_en    = 1'b0;
        trigger   = 1'b0;
        case (state)
            IDLE: begin
                if (exec_req) begin
                    exec_gnt  = 1'b1;
                    mem_en    = 1'b1;
                    mem_we    = exec_we;
                    mem_addr  = exec_addr;
                    mem_wdata = exec_wdata;
                    // The page-register write itself still reaches memory
                    if (exec_we && (exec_addr == DMA_REG_ADDR)) begin
                        trigger  = 1'b1;
                        state_nx = HALT;
                    end
                end else if (fetch_req) begin
                    fetch_gnt = 1'b1;
                    mem_en    = 1'b1;
                    mem_addr  = fetch_addr;
                    mem_wdata = exec_wdata;
                end
            end
            // Every READ must land on an even-parity cycle
            HALT:  state_nx = parity ? READ : ALIGN;
            ALIGN: state_nx = READ;
            READ: begin
                mem_en   = 1'b1;
                mem_addr = ADDR_WIDTH'({dma_page, dma_idx});
                state_nx = WRITE;
            end
            WRITE: begin
                mem_en    = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = OAM_DATA_ADDR;
                mem_wdata = dma_buf;
                state_nx  = (&dma_idx) ? IDLE : READ;
            end
            default: state_nx = IDLE;
        endcase
    end

    assign cpu_halt = (state != IDLE);
    assign rd_take  = (exec_gnt & ~exec_we) | fetch_gnt;

    // Parity, DMA datapath and registered read return
    always_ff @(posedge phi1) begin
        if (reset) begin
            parity      <= 1'b0;
            dma_idx     <= '0;
            dma_page    <= '0;
            dma_buf     <= '0;
            rdata       <= '0;
            rdata_valid <= 1'b0;
            rdata_owner <= 1'b0;
        end else begin
            parity      <= ~parity;
            rdata_valid <= rd_take;
            if (trigger) begin
                dma_page <= exec_wdata;
            end
            if (state == READ) begin
                dma_buf <= mem_rdata;
            end
            if (state == WRITE) begin
                dma_idx <= (&dma_idx) ? '0 : dma_idx + REG_WIDTH'(1);
            end
            if (rd_take) begin
                rdata       <= mem_rdata;
                rdata_owner <= exec_gnt;
            end
        end
    end

endmodule

// File: tb/tb_bus_arbiter.sv
// Testbench for bus_arbiter: transaction-level reference model feeding
// scoreboard queues, checked by an independent negedge monitor.
module tb_bus_arbiter;

    localparam logic [15:0] DMA_REG = 16'h4014;
    localparam logic [15:0] OAM     = 16'h2004;

    logic        phi1 = 1'b0;
    logic        reset;
    logic        fetch_req, fetch_gnt;
    logic [15:0] fetch_addr;
    logic        exec_req, exec_we, exec_gnt;
    logic [15:0] exec_addr;
    logic [7:0]  exec_wdata;
    logic [7:0]  mem_rdata, mem_wdata, rdata, dma_idx;
    logic [15:0] mem_addr;
    logic        mem_we, mem_en, rdata_valid, rdata_owner, cpu_halt;

    logic [7:0] ram     [0:65535];
    logic [7:0] ref_mem [0:65535];

    assign mem_rdata = ram[mem_addr];

    bus_arbiter dut (
        .phi1(phi1), .reset(reset),
        .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_gnt(fetch_gnt),
        .exec_req(exec_req), .exec_we(exec_we), .exec_addr(exec_addr),
        .exec_wdata(exec_wdata), .exec_gnt(exec_gnt),
        .mem_rdata(mem_rdata), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_we(mem_we), .mem_en(mem_en),
        .rdata(rdata), .rdata_valid(rdata_valid), .rdata_owner(rdata_owner),
        .cpu_halt(cpu_halt), .dma_idx(dma_idx)
    );

    always #5 phi1 = ~phi1;

    typedef struct {
        logic        fg, eg, halt, en, we, chk_wdata;
        logic [15:0] addr;
        logic [7:0]  wdata;
    } cyc_t;
    typedef struct { logic owner; logic [7:0] data; } rd_t;
    typedef struct { logic [7:0] idx; logic [7:0] data; } oam_t;

    cyc_t exp_cyc[$];
    rd_t  exp_rd[$];
    oam_t exp_oam[$];
    int   exp_halt[$];

    int tests = 0;
    int fails = 0;

    // Reference model state: parity of current cycle, DMA progress
    bit         m_p = 1'b0;
    int         m_halt_len = 0;
    int         m_k = 0;
    bit         m_align = 1'b0;
    logic [7:0] m_page = 8'h00;
    bit         m_fg, m_eg;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Predict this cycle's behaviour from the current requests
    task automatic model_cycle();
        cyc_t c;
        c = '{default: '0};
        m_fg = 1'b0;
        m_eg = 1'b0;
        if (reset) begin
            if (m_halt_len != 0) begin
                void'(exp_halt.pop_back());
                exp_oam.delete();
            end
            m_halt_len = 0;
        end else if (m_halt_len != 0) begin
            int j;
            j = m_k - 1 - int'(m_align);
            c.halt = 1'b1;
            if (j >= 0) begin
                c.en = 1'b1;
                if (j % 2 == 0) begin
                    c.addr = {m_page, 8'(j / 2)};
                end else begin
                    c.we   = 1'b1;
                    c.addr = OAM;
                end
            end
            m_k++;
            if (m_k == m_halt_len) m_halt_len = 0;
            exp_cyc.push_back(c);
        end else begin
            if (exec_req) begin
                m_eg = 1'b1;
                c.eg = 1'b1; c.en = 1'b1; c.we = exec_we; c.addr = exec_addr;
                if (exec_we) begin
                    c.chk_wdata = 1'b1;
                    c.wdata     = exec_wdata;
                    ref_mem[exec_addr] = exec_wdata;
                    if (exec_addr == DMA_REG) begin
                        // HALT falls on the opposite parity; HALT at p=0 needs ALIGN
                        m_align    = m_p;
                        m_halt_len = m_align ? 514 : 513;
                        m_k        = 0;
                        m_page     = exec_wdata;
                        exp_halt.push_back(m_halt_len);
                        for (int i = 0; i < 256; i++)
                            exp_oam.push_back('{8'(i), ref_mem[{exec_wdata, 8'(i)}]});
                    end
                end else begin
                    exp_rd.push_back('{1'b1, ref_mem[exec_addr]});
                end
            end else if (fetch_req) begin
                m_fg = 1'b1;
                c.fg = 1'b1; c.en = 1'b1; c.addr = fetch_addr;
                exp_rd.push_back('{1'b0, ref_mem[fetch_addr]});
            end
            exp_cyc.push_back(c);
        end
        m_p = reset ? 1'b0 : ~m_p;
    endtask

    // One clock: model, memory write capture, then drop granted requests
    task automatic step();
        model_cycle();
        @(negedge phi1);
        if (mem_en === 1'b1 && mem_we === 1'b1) ram[mem_addr] = mem_wdata;
        @(posedge phi1);
        #1;
        if (m_fg) fetch_req = 1'b0;
        if (m_eg) exec_req  = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic wait_exec_done();
        for (int i = 0; i < 600 && exec_req; i++) step();
        if (exec_req) check("exec_grant_timeout", 0, 1);
    endtask

    task automatic do_exec(input logic we, input logic [15:0] a, input logic [7:0] d);
        exec_req = 1'b1; exec_we = we; exec_addr = a; exec_wdata = d;
        wait_exec_done();
    endtask

    // Trigger DMA from a cycle whose parity is trig_p
    task automatic trigger_at(input bit trig_p, input logic [7:0] page);
        for (int i = 0; i < 2 && m_p != trig_p; i++) step();
        do_exec(1'b1, DMA_REG, page);
    endtask

    // Monitor: pops expectations whenever the DUT presents activity
    int halt_run = 0;
    always @(negedge phi1) begin
        cyc_t c;
        rd_t  r;
        oam_t o;
        if (!reset) begin
            if (exp_cyc.size() == 0) begin
                check("cycle_queue_underflow", 1, 0);
            end else begin
                c = exp_cyc.pop_front();
                check("fetch_gnt", int'(fetch_gnt), int'(c.fg));
                check("exec_gnt", int'(exec_gnt), int'(c.eg));
                check("cpu_halt", int'(cpu_halt), int'(c.halt));
                check("mem_en", int'(mem_en), int'(c.en));
                check("mem_we", int'(mem_we), int'(c.we));
                check("mem_addr", int'(mem_addr), int'(c.addr));
                if (c.chk_wdata) check("mem_wdata", int'(mem_wdata), int'(c.wdata));
                if (!c.halt) check("dma_idx_idle", int'(dma_idx), 0);
            end
            if (mem_en && mem_we && mem_addr == OAM && cpu_halt) begin
                if (exp_oam.size() == 0) begin
                    check("oam_unexpected", 1, 0);
                end else begin
                    o = exp_oam.pop_front();
                    check("oam_data", int'(mem_wdata), int'(o.data));
                    check("oam_idx", int'(dma_idx), int'(o.idx));
                end
            end
        end
        if (rdata_valid === 1'b1) begin
            if (exp_rd.size() == 0) begin
                check("rdata_unexpected", 1, 0);
            end else begin
                r = exp_rd.pop_front();
                check("rdata", int'(rdata), int'(r.data));
                check("rdata_owner", int'(rdata_owner), int'(r.owner));
            end
        end
        if (reset) begin
            halt_run = 0;
        end else if (cpu_halt) begin
            halt_run++;
        end else if (halt_run > 0) begin
            if (exp_halt.size() == 0) check("halt_unexpected", halt_run, 0);
            else check("halt_length", halt_run, exp_halt.pop_front());
            halt_run = 0;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        for (int a = 0; a < 65536; a++) ram[a] = 8'($urandom);
        for (int i = 0; i < 256; i++) ram[16'h0200 + 16'(i)] = 8'(i) ^ 8'h5A;
        ram[16'h8000] = 8'hA9;
        for (int a = 0; a < 65536; a++) ref_mem[a] = ram[a];

        reset = 1'b1; fetch_req = 1'b0; fetch_addr = '0;
        exec_req = 1'b0; exec_we = 1'b0; exec_addr = '0; exec_wdata = '0;
        @(posedge phi1); #1;
        idle(3);
        reset = 1'b0;
        check("reset_rdata", int'(rdata), 0);
        check("reset_rdata_valid", int'(rdata_valid), 0);
        check("reset_rdata_owner", int'(rdata_owner), 0);
        check("reset_cpu_halt", int'(cpu_halt), 0);
        check("reset_dma_idx", int'(dma_idx), 0);
        idle(2);

        // Fetch of 8000 returns A9
        fetch_req = 1'b1; fetch_addr = 16'h8000;
        idle(3);

        // Simultaneous fetch and exec read: exec first, then fetch
        fetch_req = 1'b1; fetch_addr = 16'h0123;
        exec_req = 1'b1; exec_we = 1'b0; exec_addr = 16'h0010;
        idle(3);

        // DMA page 02 with HALT on p=1, fetch held across it
        fetch_req = 1'b1; fetch_addr = 16'h8000;
        trigger_at(1'b0, 8'h02);
        idle(520);

        // DMA page 02 with HALT on p=0 (ALIGN cycle)
        trigger_at(1'b1, 8'h02);
        idle(520);

        // Exec read of the DMA register is an ordinary read
        do_exec(1'b0, DMA_REG, 8'h00);
        idle(3);

        // Top page, no wrap
        trigger_at(1'b0, 8'hFF);
        idle(520);

        // Reset during the WRITE of index 80, then restart
        trigger_at(1'b1, 8'h03);
        for (int i = 0; i < 600 && !(m_halt_len != 0 && m_k == 2 + int'(m_align) + 160); i++) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("abort_cpu_halt", int'(cpu_halt), 0);
        check("abort_dma_idx", int'(dma_idx), 0);
        idle(2);
        trigger_at(1'b0, 8'h03);
        idle(520);

        // Randomised traffic with occasional DMA triggers
        for (int n = 0; n < 3000; n++) begin
            if (!fetch_req && $urandom_range(0, 2) == 0) begin
                fetch_req  = 1'b1;
                fetch_addr = 16'($urandom);
                if (fetch_addr == OAM) fetch_addr = 16'h0000;
            end
            if (!exec_req && $urandom_range(0, 2) == 0) begin
                exec_req   = 1'b1;
                exec_we    = 1'($urandom);
                exec_addr  = 16'($urandom);
                exec_wdata = 8'($urandom);
                if (exec_addr == OAM || exec_addr == DMA_REG) exec_addr = 16'h0001;
                if ($urandom_range(0, 199) == 0) begin
                    exec_we   = 1'b1;
                    exec_addr = DMA_REG;
                    if (exec_wdata == 8'h20) exec_wdata = 8'h21;
                end
            end
            step();
        end
        fetch_req = 1'b0;
        exec_req  = 1'b0;
        idle(530);

        check("rd_queue_empty", exp_rd.size(), 0);
        check("oam_queue_empty", exp_oam.size(), 0);
        check("halt_queue_empty", exp_halt.size(), 0);
        check("cycle_queue_empty", exp_cyc.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/bus_arbiter.md
Name: bus_arbiter

Overview:
- Owns the single CPU memory port and shares it between the instruction fetcher and the execution unit (data loads/stores, stack accesses).
- Contains the OAM DMA sequencer. A write to the DMA page register halts the CPU and copies 256 bytes from page {page,00..FF} to OAM_DATA_ADDR.
- Sits between the fetcher/execution unit and the memory map decoder.

Parameters:
- REG_WIDTH, 8, data width
- ADDR_WIDTH, 16, address width
- DMA_REG_ADDR, 16'h4014, write address that triggers OAM DMA
- OAM_DATA_ADDR, 16'h2004, DMA write destination

Ports:
- phi1  in  1  clock; all state updates on posedge phi1
- reset  in  1  synchronous, active-high reset
- fetch_req  in  1  fetcher requests a read
- fetch_addr  in  16  fetcher read address
- fetch_gnt  out  1  fetcher access performed this cycle
- exec_req  in  1  execution unit requests an access
- exec_we  in  1  1 = write, 0 = read
- exec_addr  in  16  execution unit address
- exec_wdata  in  8  execution unit write data
- exec_gnt  out  1  execution unit access performed this cycle
- mem_rdata  in  8  memory read data, valid in the cycle of access
- mem_addr  out  16  memory address
- mem_wdata  out  8  memory write data
- mem_we  out  1  memory write strobe
- mem_en  out  1  memory access enable
- rdata  out  8  registered read data for the last granted CPU read
- rdata_valid  out  1  one-cycle pulse, rdata updated
- rdata_owner  out  1  0 = fetcher, 1 = execution unit
- cpu_halt  out  1  CPU must stall; asserted for all DMA states
- dma_idx  out  8  current DMA byte index (debug/verification)

Behaviour:
- Interface: one clock, phi1; synchronous active-high reset.
- Reset: state = IDLE, parity = 0, dma_idx = 0, dma_page = 0, dma_buf = 0, rdata = 0. rdata_valid, rdata_owner, cpu_halt = 0. All grants and mem_* = 0 (combinational outputs follow IDLE with no requests).
- Reset mid-DMA: aborts the transfer immediately, returns to IDLE and releases cpu_halt. Partially written OAM is not rolled back.
- Parity bit: toggles every cycle, reset to 0. Value p is the parity of the current cycle.
- Grants and mem_* are combinational from state, requests and addresses. rdata, rdata_valid and rdata_owner are registered: updated at the posedge ending a granted read.
- Read latency: rdata is valid 1 cycle after the grant.
- Requesters hold req and addr stable until their gnt is seen. At most one grant per cycle.

IDLE:
- Fixed priority: exec over fetch.
- Granted access drives mem_addr, mem_we = exec_we (0 for fetch), mem_wdata = exec_wdata, mem_en = 1.
- No request: mem_en = 0, mem_addr = 0.
- A granted exec write with exec_addr == DMA_REG_ADDR also performs the memory write. At the same edge: dma_page <= exec_wdata, go to HALT.

HALT (1 cycle):
- cpu_halt = 1, grants = 0, mem_en = 0.
- p == 1 -> READ; p == 0 -> ALIGN.

ALIGN (1 cycle):
- Same outputs as HALT, then -> READ.

READ:
- mem_addr = {dma_page, dma_idx}, mem_en = 1, mem_we = 0. Always lands on p == 0.
- dma_buf <= mem_rdata; rdata_valid stays 0.
- -> WRITE.

WRITE:
- mem_addr = OAM_DATA_ADDR, mem_wdata = dma_buf, mem_we = 1, mem_en = 1.
- dma_idx == 255: dma_idx <= 0, -> IDLE.
- Else: dma_idx += 1 (8-bit), -> READ.

Totals:
- CPU halted for 513 cycles (HALT at p = 1) or 514 cycles (HALT at p = 0).
- The first CPU grant is possible in the cycle after the final WRITE.

Boundaries:
- Requests during DMA are ignored (gnt = 0), not queued; they are served on return to IDLE under normal priority.
- An exec read of DMA_REG_ADDR is an ordinary read with no trigger.
- Simultaneous exec trigger write and fetch_req: exec is granted and the fetch waits through the DMA.
- dma_page = FF reads FF00..FFFF with no wrap into other pages.

Test Plan:
- Reset, then fetch_req = 1, fetch_addr = 8000, memory holds A9 -> same cycle fetch_gnt = 1, mem_addr = 8000, mem_en = 1. Next cycle rdata = A9, rdata_valid = 1, rdata_owner = 0.
- fetch_req and exec_req (read 0010) in the same cycle -> exec_gnt = 1, fetch_gnt = 0. Next cycle fetch granted; rdata_owner sequence is 1 then 0.
- Exec write 02 to 4014 with HALT at p = 1; RAM 0200+i = i ^ 5A -> cpu_halt high exactly 513 cycles. 256 writes to 2004 carry data i ^ 5A in order; dma_idx ends at 0.
- Same trigger as above but HALT at p = 0 -> one ALIGN cycle, cpu_halt high 514 cycles, every READ on p = 0.
- fetch_req held through DMA -> fetch_gnt = 0 throughout; granted the first cycle after the final WRITE.
- Assert reset at dma_idx = 80 during WRITE -> next cycle IDLE, cpu_halt = 0, dma_idx = 0. A new trigger restarts the copy from index 0.
